// File: rtl/tron_pkg.sv
// Shared types for the round judge: FSM states and player identifiers.
package tron_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        SETTLE,
        ANNOUNCE,
        MATCH_END
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        P1,
        P2
    } player_t;

    localparam int TALLY_W   = 4;
    localparam int TALLY_MAX = 15;

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter stepped by the frame tick; stops at zero and flags it.
module tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         zero
);

    // A load wins over a tick in the same cycle; otherwise count down to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/round_judge.sv
// Round referee for a two-player light-cycle game: detects crashes, resolves
// near-simultaneous crashes as draws, announces winners and tracks the match.
module round_judge
    import tron_pkg::*;
#(
    parameter int SETTLE_TICKS   = 2,
    parameter int ANNOUNCE_TICKS = 60,
    parameter int MATCH_WINS     = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic start,
    input  logic crash_p1,
    input  logic crash_p2,
    output logic running,
    output logic p1_won,
    output logic p2_won,
    output logic win_strobe,
    output logic draw,
    output logic match_over,
    output logic score_clear
);

    localparam int MAX_TICKS = (SETTLE_TICKS > ANNOUNCE_TICKS) ? SETTLE_TICKS : ANNOUNCE_TICKS;
    localparam int TIMER_W   = (MAX_TICKS < 2) ? 1 : $clog2(MAX_TICKS + 1);

    localparam logic [TIMER_W-1:0] SETTLE_LOAD   = TIMER_W'(SETTLE_TICKS);
    localparam logic [TIMER_W-1:0] ANNOUNCE_LOAD = TIMER_W'(ANNOUNCE_TICKS);
    localparam logic [TALLY_W-1:0] WIN_LIMIT     = TALLY_W'(MATCH_WINS);
    localparam logic [TALLY_W-1:0] TALLY_TOP     = TALLY_W'(TALLY_MAX);

    state_t               state;
    player_t              crasher;
    logic [TALLY_W-1:0]   p1_tally;
    logic [TALLY_W-1:0]   p2_tally;

    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_value;
    logic [TIMER_W-1:0]   timer_count;
    logic                 timer_zero;
    logic                 timer_done;
    logic                 other_crash;

    tick_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .load       (timer_load),
        .load_value (timer_value),
        .count      (timer_count),
        .zero       (timer_zero)
    );

    // The timer expires either when already empty or when this tick takes its last step,
    // so the decision is made in the same cycle as the deciding tick.
    assign timer_done  = timer_zero || (tick && (timer_count == TIMER_W'(1)));
    assign other_crash = ((crasher == P1) && crash_p2) || ((crasher == P2) && crash_p1);

    assign running    = (state == PLAY) || (state == SETTLE);
    assign match_over = (state == MATCH_END);

    // Reload the shared timer on every transition into SETTLE or ANNOUNCE.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            PLAY: begin
                if (crash_p1 && crash_p2) begin
                    timer_load  = 1'b1;
                    timer_value = ANNOUNCE_LOAD;
                end else if (crash_p1 || crash_p2) begin
                    timer_load  = 1'b1;
                    timer_value = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (other_crash || timer_done) begin
                    timer_load  = 1'b1;
                    timer_value = ANNOUNCE_LOAD;
                end
            end
            default: begin
                timer_load  = 1'b0;
                timer_value = '0;
            end
        endcase
    end

    // Round FSM with registered result flags, strobes and win tallies.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            crasher     <= NONE;
            p1_tally    <= '0;
            p2_tally    <= '0;
            p1_won      <= 1'b0;
            p2_won      <= 1'b0;
            draw        <= 1'b0;
            win_strobe  <= 1'b0;
            score_clear <= 1'b1;
        end else begin
            win_strobe  <= 1'b0;
            score_clear <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    if (crash_p1 && crash_p2) begin
                        state  <= ANNOUNCE;
                        draw   <= 1'b1;
                        p1_won <= 1'b0;
                        p2_won <= 1'b0;
                    end else if (crash_p1) begin
                        state   <= SETTLE;
                        crasher <= P1;
                    end else if (crash_p2) begin
                        state   <= SETTLE;
                        crasher <= P2;
                    end
                end
                SETTLE: begin
                    if (other_crash) begin
                        state  <= ANNOUNCE;
                        draw   <= 1'b1;
                        p1_won <= 1'b0;
                        p2_won <= 1'b0;
                    end else if (timer_done) begin
                        state      <= ANNOUNCE;
                        draw       <= 1'b0;
                        win_strobe <= 1'b1;
                        if (crasher == P1) begin
                            p1_won <= 1'b0;
                            p2_won <= 1'b1;
                            if (p2_tally != TALLY_TOP) begin
                                p2_tally <= p2_tally + TALLY_W'(1);
                            end
                        end else begin
                            p1_won <= 1'b1;
                            p2_won <= 1'b0;
                            if (p1_tally != TALLY_TOP) begin
                                p1_tally <= p1_tally + TALLY_W'(1);
                            end
                        end
                    end
                end
                ANNOUNCE: begin
                    if (timer_done) begin
                        if ((p1_tally >= WIN_LIMIT) || (p2_tally >= WIN_LIMIT)) begin
                            state <= MATCH_END;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                MATCH_END: begin
                    if (start) begin
                        state       <= IDLE;
                        p1_tally    <= '0;
                        p2_tally    <= '0;
                        p1_won      <= 1'b0;
                        p2_won      <= 1'b0;
                        draw        <= 1'b0;
                        score_clear <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_judge.sv
// Self-checking bench for round_judge: a table of per-cycle vectors plus
// hand-written sequences, with expected outputs queued and popped after each edge.
module tb_round_judge;

    logic clk;
    logic reset;
    logic tick;
    logic start;
    logic crash_p1;
    logic crash_p2;

    logic running, p1_won, p2_won, win_strobe, draw, match_over, score_clear;
    logic running0, p1_won0, p2_won0, win_strobe0, draw0, match_over0, score_clear0;

    int total = 0;
    int bad   = 0;

    // expected output order: {running, p1_won, p2_won, win_strobe, draw, match_over, score_clear}
    typedef struct {
        string      name;
        logic [4:0] stim;
        logic [6:0] expect_out;
    } vec_t;

    typedef struct {
        string      name;
        logic [6:0] expect_out;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    round_judge #(
        .SETTLE_TICKS   (2),
        .ANNOUNCE_TICKS (2),
        .MATCH_WINS     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .start       (start),
        .crash_p1    (crash_p1),
        .crash_p2    (crash_p2),
        .running     (running),
        .p1_won      (p1_won),
        .p2_won      (p2_won),
        .win_strobe  (win_strobe),
        .draw        (draw),
        .match_over  (match_over),
        .score_clear (score_clear)
    );

    round_judge #(
        .SETTLE_TICKS   (0),
        .ANNOUNCE_TICKS (2),
        .MATCH_WINS     (2)
    ) dut0 (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .start       (start),
        .crash_p1    (crash_p1),
        .crash_p2    (crash_p2),
        .running     (running0),
        .p1_won      (p1_won0),
        .p2_won      (p2_won0),
        .win_strobe  (win_strobe0),
        .draw        (draw0),
        .match_over  (match_over0),
        .score_clear (score_clear0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void addVec(input string nm, input logic [4:0] stim, input logic [6:0] ex);
        vec_t v;
        v.name       = nm;
        v.stim       = stim;
        v.expect_out = ex;
        vecs.push_back(v);
    endfunction

    function automatic void checkVal(input string nm, input logic [6:0] actual, input logic [6:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", nm, actual, required, $time);
        end
    endfunction

    // Pop the oldest expectation and compare it with the main DUT's outputs.
    task automatic checkOutput();
        sb_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard: empty queue at %0t", $time);
        end else begin
            e = sb.pop_front();
            checkVal(e.name, {running, p1_won, p2_won, win_strobe, draw, match_over, score_clear},
                     e.expect_out);
        end
    endtask

    // Drive one cycle of stimulus {reset,start,tick,crash_p1,crash_p2}, queue its result, check after the edge.
    task automatic applyStimulus(input string nm, input logic [4:0] stim, input logic [6:0] ex);
        sb_t e;
        {reset, start, tick, crash_p1, crash_p2} = stim;
        e.name       = nm;
        e.expect_out = ex;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkTally(input string nm, input logic [3:0] p1, input logic [3:0] p2);
        checkVal(nm, {3'b000, dut.p1_tally}, {3'b000, p1});
        checkVal(nm, {3'b000, dut.p2_tally}, {3'b000, p2});
    endtask

    initial begin
        {reset, start, tick, crash_p1, crash_p2} = 5'b00000;

        // single crash by p1, p2 survives the settle window
        addVec("reset",          5'b10000, 7'b0000001);
        addVec("idle",           5'b00000, 7'b0000000);
        addVec("start",          5'b01000, 7'b1000000);
        addVec("play",           5'b00000, 7'b1000000);
        addVec("play_tick",      5'b00100, 7'b1000000);
        addVec("play_start",     5'b01000, 7'b1000000);
        addVec("crash_p1",       5'b00010, 7'b1000000);
        addVec("settle_tick1",   5'b00100, 7'b1000000);
        addVec("settle_wait",    5'b00000, 7'b1000000);
        addVec("settle_same",    5'b00010, 7'b1000000);
        addVec("settle_tick2",   5'b00100, 7'b0011000);
        addVec("ann_hold",       5'b00000, 7'b0010000);
        addVec("ann_start",      5'b01000, 7'b0010000);
        addVec("ann_tick1",      5'b00100, 7'b0010000);
        addVec("ann_tick2",      5'b00110, 7'b0010000);
        addVec("idle_crash",     5'b00011, 7'b0010000);
        addVec("idle_tick",      5'b00100, 7'b0010000);
        // simultaneous crash in PLAY
        addVec("t2_start",       5'b01000, 7'b1010000);
        addVec("t2_both",        5'b00011, 7'b0000100);
        addVec("t2_tick1",       5'b00100, 7'b0000100);
        addVec("t2_tick2",       5'b00100, 7'b0000100);
        // second crash inside the settle window
        addVec("t3_start",       5'b01000, 7'b1000100);
        addVec("t3_crash_p2",    5'b00001, 7'b1000100);
        addVec("t3_tick1",       5'b00100, 7'b1000100);
        addVec("t3_crash_p1",    5'b00010, 7'b0000100);
        addVec("t3_ann_tick1",   5'b00100, 7'b0000100);
        addVec("t3_ann_tick2",   5'b00100, 7'b0000100);
        // second crash together with the final tick
        addVec("t3b_start",      5'b01000, 7'b1000100);
        addVec("t3b_crash_p2",   5'b00001, 7'b1000100);
        addVec("t3b_tick1",      5'b00100, 7'b1000100);
        addVec("t3b_tick2_p1",   5'b00110, 7'b0000100);
        addVec("t3b_ann_tick1",  5'b00100, 7'b0000100);
        addVec("t3b_ann_tick2",  5'b00100, 7'b0000100);
        // two p1 wins end the match
        addVec("t4_start",       5'b01000, 7'b1000100);
        addVec("t4_crash_p2",    5'b00001, 7'b1000100);
        addVec("t4_tick1",       5'b00100, 7'b1000100);
        addVec("t4_tick2",       5'b00100, 7'b0101000);
        addVec("t4_ann_tick1",   5'b00100, 7'b0100000);
        addVec("t4_ann_tick2",   5'b00100, 7'b0100000);
        addVec("t4_start2",      5'b01000, 7'b1100000);
        addVec("t4_crash_p2b",   5'b00001, 7'b1100000);
        addVec("t4_tick1b",      5'b00100, 7'b1100000);
        addVec("t4_tick2b",      5'b00100, 7'b0101000);
        addVec("t4_ann_tick1b",  5'b00100, 7'b0100000);
        addVec("t4_ann_tick2b",  5'b00100, 7'b0100010);
        addVec("mend_tick_crash",5'b00111, 7'b0100010);
        addVec("mend_both",      5'b00011, 7'b0100010);
        addVec("mend_start",     5'b01000, 7'b0000001);
        addVec("held_start",     5'b01000, 7'b1000000);
        addVec("post_both",      5'b00011, 7'b0000100);
        addVec("post_tick1",     5'b00100, 7'b0000100);
        addVec("post_tick2",     5'b00100, 7'b0000100);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].name, vecs[i].stim, vecs[i].expect_out);
        end
        checkTally("tally_after_clear", 4'd0, 4'd0);

        // reset in the middle of SETTLE after a p1 win
        applyStimulus("t5_start",      5'b01000, 7'b1000100);
        applyStimulus("t5_crash_p2",   5'b00001, 7'b1000100);
        applyStimulus("t5_tick1",      5'b00100, 7'b1000100);
        applyStimulus("t5_tick2",      5'b00100, 7'b0101000);
        applyStimulus("t5_ann_tick1",  5'b00100, 7'b0100000);
        applyStimulus("t5_ann_tick2",  5'b00100, 7'b0100000);
        checkTally("tally_one_win", 4'd1, 4'd0);
        applyStimulus("t5_start2",     5'b01000, 7'b1100000);
        applyStimulus("t5_crash_p1",   5'b00010, 7'b1100000);
        applyStimulus("t5_settle_tick",5'b00100, 7'b1100000);
        applyStimulus("t5_reset",      5'b10000, 7'b0000001);
        checkTally("tally_after_reset", 4'd0, 4'd0);
        applyStimulus("t5_idle",       5'b00000, 7'b0000000);
        applyStimulus("t5_start3",     5'b01000, 7'b1000000);
        applyStimulus("t5_crash_p1b",  5'b00010, 7'b1000000);
        applyStimulus("t5_tick1b",     5'b00100, 7'b1000000);
        applyStimulus("t5_tick2b",     5'b00100, 7'b0011000);
        applyStimulus("t5_ann_tick1",  5'b00100, 7'b0010000);
        applyStimulus("t5_ann_tick2",  5'b00100, 7'b0010000);
        checkTally("tally_clean_round", 4'd0, 4'd1);

        // zero-length settle window decides on the cycle after entering SETTLE
        applyStimulus("z_reset",       5'b10000, 7'b0000001);
        checkVal("z0_reset", {running0, p1_won0, p2_won0, win_strobe0, draw0, match_over0, score_clear0},
                 7'b0000001);
        applyStimulus("z_start",       5'b01000, 7'b1000000);
        applyStimulus("z_crash_p1",    5'b00010, 7'b1000000);
        checkVal("z0_settle", {running0, p1_won0, p2_won0, win_strobe0, draw0, match_over0, score_clear0},
                 7'b1000000);
        applyStimulus("z_wait",        5'b00000, 7'b1000000);
        checkVal("z0_decide", {running0, p1_won0, p2_won0, win_strobe0, draw0, match_over0, score_clear0},
                 7'b0011000);
        applyStimulus("z_wait2",       5'b00000, 7'b1000000);
        checkVal("z0_strobe_drop", {running0, p1_won0, p2_won0, win_strobe0, draw0, match_over0, score_clear0},
                 7'b0010000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
